// File: rtl/multiplier_result_port_pkg.sv
// Shared accelerator constants for the multiplier result port.
// The write-side decoder of the multiplier uses the same word offsets.
package multiplier_result_port_pkg;

   localparam logic ADDR_LOW  = 1'b0;
   localparam logic ADDR_HIGH = 1'b1;

endpackage

// File: rtl/multiplier_result_port_delay_line.sv
// Fixed-length shift register.
// A value presented on i_data appears on o_data exactly DEPTH cycles later.
module Delay_Line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   logic [DEPTH-1:0][WIDTH-1:0] r_stages;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_stages <= '0;
      end else begin
         r_stages <= {r_stages[DEPTH-2:0], i_data};
      end
   end

   assign o_data = r_stages[DEPTH-1];

endmodule

// File: rtl/multiplier_result_port.sv
// Per-thread result buffer for a round-robin multithreaded multiplier.
// It captures pipeline results into per-thread slots and serves reads with an empty/retry flag.
module multiplier_result_port
   import multiplier_result_port_pkg::*;
#(
   parameter int WORD_WIDTH   = 36,
   parameter int THREAD_COUNT = 8,
   parameter int PIPE_DEPTH   = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  issue,
   input  logic [WORD_WIDTH-1:0] R_low,
   input  logic [WORD_WIDTH-1:0] R_high,
   input  logic                  read_enable,
   input  logic                  read_addr,
   output logic [WORD_WIDTH-1:0] read_data,
   output logic                  read_empty,
   output logic                  overrun
);

   localparam int TW = $clog2(THREAD_COUNT);
   localparam logic [TW-1:0] LAST_THREAD = TW'(THREAD_COUNT - 1);

   logic [TW-1:0]           r_thread;
   logic [THREAD_COUNT-1:0] r_full;
   logic [WORD_WIDTH-1:0]   r_slotLow  [THREAD_COUNT];
   logic [WORD_WIDTH-1:0]   r_slotHigh [THREAD_COUNT];

   logic                  w_capture;
   logic                  w_slotFull;
   logic                  w_consume;
   logic [WORD_WIDTH-1:0] w_selWord;

   // Because the delay equals the thread count, the delayed issue lands back on the issuing thread.
   Delay_Line #(
      .WIDTH(1),
      .DEPTH(PIPE_DEPTH)
   ) u_issueDelay (
      .clock (clock),
      .reset (reset),
      .i_data(issue),
      .o_data(w_capture)
   );

   assign w_slotFull = r_full[r_thread];
   assign w_consume  = read_enable && (read_addr == ADDR_HIGH) && w_slotFull;
   assign w_selWord  = (read_addr == ADDR_LOW) ? r_slotLow[r_thread] : r_slotHigh[r_thread];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_thread <= '0;
      end else if (r_thread == LAST_THREAD) begin
         r_thread <= '0;
      end else begin
         r_thread <= r_thread + 1'b1;
      end
   end

   // Slot contents carry no reset; the full bits alone decide whether a slot is valid.
   always_ff @(posedge clock) begin
      if (w_capture) begin
         r_slotLow[r_thread]  <= R_low;
         r_slotHigh[r_thread] <= R_high;
      end
   end

   // A capture takes priority over a high-word consume, so a slot refilled in the same cycle stays full.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_full     <= '0;
         read_data  <= '0;
         read_empty <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= w_capture && w_slotFull;
         if (w_capture) begin
            r_full[r_thread] <= 1'b1;
         end else if (w_consume) begin
            r_full[r_thread] <= 1'b0;
         end
         if (read_enable) begin
            read_data  <= w_slotFull ? w_selWord : '0;
            read_empty <= !w_slotFull;
         end else begin
            read_empty <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_multiplier_result_port.sv
// Directed-vector bench for multiplier_result_port.
// Each table entry holds one cycle of stimulus and the outputs expected after that cycle's clock edge.
module tb_multiplier_result_port;

   localparam int W = 36;
   localparam int NV = 40;

   typedef struct {
      logic         issue;
      logic [W-1:0] rLow;
      logic [W-1:0] rHigh;
      logic         ren;
      logic         raddr;
      logic         dataValid;
      logic [W-1:0] expData;
      logic         expEmpty;
      logic         expOverrun;
   } vec_t;

   logic         clock;
   logic         reset;
   logic         issue;
   logic [W-1:0] R_low;
   logic [W-1:0] R_high;
   logic         read_enable;
   logic         read_addr;
   logic [W-1:0] read_data;
   logic         read_empty;
   logic         overrun;

   int   errors;
   int   checks;
   vec_t vecs [NV];

   multiplier_result_port #(
      .WORD_WIDTH  (W),
      .THREAD_COUNT(8),
      .PIPE_DEPTH  (8)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .issue      (issue),
      .R_low      (R_low),
      .R_high     (R_high),
      .read_enable(read_enable),
      .read_addr  (read_addr),
      .read_data  (read_data),
      .read_empty (read_empty),
      .overrun    (overrun)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic applyStimulus(input logic iss, input logic [W-1:0] lo, input logic [W-1:0] hi,
                                input logic ren, input logic raddr);
      issue       = iss;
      R_low       = lo;
      R_high      = hi;
      read_enable = ren;
      read_addr   = raddr;
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic doReset();
      reset       = 1'b1;
      issue       = 1'b0;
      read_enable = 1'b0;
      read_addr   = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic setResult(input int c, input logic [W-1:0] lo, input logic [W-1:0] hi);
      vecs[c].rLow  = lo;
      vecs[c].rHigh = hi;
   endtask

   task automatic setRead(input int c, input logic addr, input logic [W-1:0] data, input logic empty);
      vecs[c].ren       = 1'b1;
      vecs[c].raddr     = addr;
      vecs[c].dataValid = 1'b1;
      vecs[c].expData   = data;
      vecs[c].expEmpty  = empty;
   endtask

   initial begin
      logic [W-1:0] heldData;
      logic [W-1:0] expWord;
      errors = 0;
      checks = 0;
      R_low  = '0;
      R_high = '0;

      // Background result words change every cycle so a capture at the wrong time is visible.
      for (int c = 0; c < NV; c++) begin
         vecs[c].issue      = 1'b0;
         vecs[c].rLow       = 36'h100 + 36'(c);
         vecs[c].rHigh      = 36'h200 + 36'(c);
         vecs[c].ren        = 1'b0;
         vecs[c].raddr      = 1'b0;
         vecs[c].dataValid  = 1'b0;
         vecs[c].expData    = '0;
         vecs[c].expEmpty   = 1'b0;
         vecs[c].expOverrun = 1'b0;
      end
      vecs[1].issue = 1'b1;
      vecs[3].issue = 1'b1;
      vecs[5].issue = 1'b1;
      vecs[6].issue = 1'b1;
      vecs[13].issue = 1'b1;
      vecs[14].issue = 1'b1;
      setResult(9,  36'h11, 36'h12);
      setResult(11, 36'h5,  36'h1);
      setResult(13, 36'hA1, 36'hA2);
      setResult(14, 36'h61, 36'h62);
      setResult(21, 36'hB1, 36'hB2);
      setResult(22, 36'h63, 36'h64);
      setRead(2,  1'b0, 36'h0,  1'b1);
      setRead(17, 1'b1, 36'h12, 1'b0);
      setRead(19, 1'b1, 36'h1,  1'b0);
      setRead(22, 1'b1, 36'h62, 1'b0);
      setRead(25, 1'b0, 36'h0,  1'b1);
      setRead(27, 1'b1, 36'h0,  1'b1);
      setRead(29, 1'b0, 36'hB1, 1'b0);
      setRead(30, 1'b0, 36'h63, 1'b0);
      setRead(37, 1'b1, 36'hB2, 1'b0);
      vecs[21].expOverrun = 1'b1;
      vecs[22].expOverrun = 1'b1;

      reset       = 1'b1;
      issue       = 1'b0;
      read_enable = 1'b0;
      read_addr   = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset read_data", read_data, '0);
      checkOutput("reset read_empty", {35'b0, read_empty}, '0);
      checkOutput("reset overrun", {35'b0, overrun}, '0);
      reset = 1'b0;

      heldData = '0;
      for (int c = 0; c < NV; c++) begin
         applyStimulus(vecs[c].issue, vecs[c].rLow, vecs[c].rHigh, vecs[c].ren, vecs[c].raddr);
         if (vecs[c].dataValid) heldData = vecs[c].expData;
         checkOutput($sformatf("table c%0d read_data", c), read_data, heldData);
         checkOutput($sformatf("table c%0d read_empty", c), {35'b0, read_empty}, {35'b0, vecs[c].expEmpty});
         checkOutput($sformatf("table c%0d overrun", c), {35'b0, overrun}, {35'b0, vecs[c].expOverrun});
      end

      $display("[TB] back-to-back issue from every thread");
      doReset();
      for (int c = 0; c < 32; c++) begin
         if (c >= 8 && c < 16)
            applyStimulus(1'b0, 36'(c - 8), 36'h80 + 36'(c - 8), 1'b0, 1'b0);
         else
            applyStimulus(c < 8, 36'hFFF, 36'hEEE, c >= 16, c >= 24);
         if (c >= 16) begin
            expWord = (c < 24) ? 36'(c - 16) : 36'h80 + 36'(c - 24);
            checkOutput($sformatf("b2b c%0d read_data", c), read_data, expWord);
            checkOutput($sformatf("b2b c%0d read_empty", c), {35'b0, read_empty}, '0);
         end
         checkOutput($sformatf("b2b c%0d overrun", c), {35'b0, overrun}, '0);
      end

      $display("[TB] reset with an issue in flight");
      doReset();
      for (int c = 0; c < 6; c++) begin
         applyStimulus(c == 2, 36'h777, 36'h778, 1'b0, 1'b0);
      end
      reset = 1'b1;
      #1;
      checkOutput("midreset read_empty", {35'b0, read_empty}, '0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      for (int c = 0; c < 18; c++) begin
         applyStimulus(c == 0, 36'h300 + 36'(c), 36'h400 + 36'(c), c >= 8, 1'b0);
         if (c >= 8) begin
            expWord = (c == 16) ? 36'h308 : 36'h0;
            checkOutput($sformatf("postreset c%0d read_data", c), read_data, expWord);
            checkOutput($sformatf("postreset c%0d read_empty", c), {35'b0, read_empty},
                        {35'b0, (c != 16)});
         end
         checkOutput($sformatf("postreset c%0d overrun", c), {35'b0, overrun}, '0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multiplier_result_port.md
MULTIPLIER_RESULT_PORT -- requirements
Module: multiplier_result_port

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 36, width of each result word.
REQ-002 SHALL have parameter THREAD_COUNT, default 8, number of round-robin threads; even, at least 4.
REQ-003 SHALL have parameter PIPE_DEPTH, default 8, cycles from issue to R_low/R_high valid; equals THREAD_COUNT.
REQ-004 SHALL have port: clock  input  1  sole clock, rising edge.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port: issue  input  1  current thread started a multiply this cycle (B write).
REQ-007 SHALL have port: R_low  input  WORD_WIDTH  low result word from the multiplier pipeline.
REQ-008 SHALL have port: R_high  input  WORD_WIDTH  high result word from the multiplier pipeline.
REQ-009 SHALL have port: read_enable  input  1  current thread reads the result port.
REQ-010 SHALL have port: read_addr  input  1  0 selects low word, 1 selects high word.
REQ-011 SHALL have port: read_data  output  WORD_WIDTH  registered selected word.
REQ-012 SHALL have port: read_empty  output  1  registered; 1 means the read had no result and must be annulled and retried.
REQ-013 SHALL have port: overrun  output  1  registered one-cycle pulse; an unconsumed result was overwritten.

Function
REQ-014 SHALL keep an internal thread counter: 0 after reset, +1 per cycle, wrapping THREAD_COUNT-1 -> 0.
REQ-015 SHALL delay issue by exactly PIPE_DEPTH cycles; a delayed issue of 1 captures R_low/R_high into the slot of the current thread, which is the issuing thread.
REQ-016 SHALL set full[t] on capture; if full[t] was already 1, overwrite the data and pulse overrun in the next cycle.
REQ-017 SHALL, when read_enable=1, present in the next cycle read_data = selected word of the current thread's slot and read_empty = !full[t].
REQ-018 SHALL drive read_data to zero whenever full[t] is 0 at the read.
REQ-019 SHALL clear full[t] on a read with read_addr=1 while full[t]=1; a low-word read SHALL NOT clear it.
REQ-020 SHALL, when capture and high-word consume hit the same thread in the same cycle, return the old data, pulse overrun, and leave full[t]=1 holding the new data.
REQ-021 SHALL, when read_enable=0, hold read_data and drive read_empty to 0 in the next cycle.
REQ-022 SHALL allow issue in consecutive cycles from all threads, giving one capture per cycle, with no stall.

Reset
REQ-023 SHALL, while reset=1, clear the thread counter, the issue delay line, all full bits, read_data, read_empty and overrun; slot data is don't-care.
REQ-024 SHALL discard in-flight issues on reset mid-operation; results arriving after deassertion SHALL NOT be captured.
REQ-025 SHALL resume counting from thread 0 on the first clock edge after reset deasserts.

Structure
REQ-026 SHALL take the low/high address offsets (0/1) from the shared accelerator constants include, which the multiplier's write-side decoder also uses.
REQ-027 SHALL implement the issue delay with the existing Delay_Line sub-module (WIDTH 1, DEPTH PIPE_DEPTH).
REQ-028 SHALL keep per-thread slots in registers, indexed by the thread counter.

Verification
REQ-029 Thread 3 issues at cycle 3 with R_low=0x5, R_high=0x1 at cycle 11; thread 3 reads high at cycle 19 -> read_data=0x1, read_empty=0 at cycle 20.
REQ-030 Thread 2 reads low at cycle 2 with no prior issue -> read_empty=1 and read_data=0 at cycle 3.
REQ-031 Thread 5 issues twice, 8 cycles apart, with no read between -> overrun=1 one cycle after the second capture; a later read returns the second result.
REQ-032 All 8 threads issue on consecutive cycles with R_low equal to the thread number -> each thread's later low read returns its own number.
REQ-033 Thread 1 reads high and then low one round later -> first read returns data with read_empty=0; second read has read_empty=1.
REQ-034 Reset asserted 4 cycles after an issue and released -> no capture occurs, the first read has read_empty=1, and the thread counter restarts at 0.
